// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku hint writer.
//   CELLS/CELL_W/BOARD_W : board geometry (81 cells of 4 bits, cell i = row*9+col)
//   state_t              : hint engine FSM states
//   cell_idx/cell_val    : board addressing helpers
//   digit_bit            : digit -> bit in a 10-bit "digit used" vector (0 or >9 contribute nothing)
package sudoku_pkg;

  localparam int CELLS   = 81;
  localparam int CELL_W  = 4;
  localparam int BOARD_W = CELLS * CELL_W;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    EMIT,
    HOLD,
    FIN
  } state_t;

  function automatic logic [6:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
    return 7'(r) * 7'd9 + 7'(c);
  endfunction

  function automatic logic [CELL_W-1:0] cell_val(input logic [BOARD_W-1:0] board,
                                                 input logic [6:0] i);
    return board[int'(i)*CELL_W +: CELL_W];
  endfunction

  function automatic logic [9:0] digit_bit(input logic [CELL_W-1:0] v);
    if (v == 4'd0 || v > 4'd9) return '0;
    return 10'd1 << v;
  endfunction

endpackage

// File: rtl/sudoku_hint_writer_if.sv
// Game <-> hint engine bundle.
//   hint_req, game_active, board, board_blank : game side to engine
//   read/row/col/data                          : cell-write strobe to game
//   busy, done, found, stuck                   : engine status
// master = game/requester side, slave = hint engine.
interface sudoku_hint_writer_if;

  logic                          hint_req;
  logic                          game_active;
  logic [sudoku_pkg::BOARD_W-1:0] board;
  logic [sudoku_pkg::CELLS-1:0]   board_blank;
  logic                          read;
  logic [3:0]                    row;
  logic [3:0]                    col;
  logic [3:0]                    data;
  logic                          busy;
  logic                          done;
  logic                          found;
  logic                          stuck;

  modport master (
    output hint_req, game_active, board, board_blank,
    input  read, row, col, data, busy, done, found, stuck
  );

  modport slave (
    input  hint_req, game_active, board, board_blank,
    output read, row, col, data, busy, done, found, stuck
  );

endinterface

// File: rtl/sudoku_candidates.sv
// Combinational candidate evaluation for one cell.
//   board  : full board
//   r, c   : cell coordinates 0..8
//   cand   : bit k set iff digit k+1 is absent from the row, column and 3x3 block
//   cnt    : number of candidates
//   digit  : lowest candidate digit (1..9), 0 when there is none
module sudoku_candidates
  import sudoku_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [3:0]         r,
  input  logic [3:0]         c,
  output logic [8:0]         cand,
  output logic [3:0]         cnt,
  output logic [3:0]         digit
);

  logic [3:0] br;
  logic [3:0] bc;
  logic [9:0] used;

  always_comb begin
    br = (r >= 4'd6) ? 4'd6 : (r >= 4'd3) ? 4'd3 : 4'd0;
    bc = (c >= 4'd6) ? 4'd6 : (c >= 4'd3) ? 4'd3 : 4'd0;
    used = '0;
    for (int unsigned j = 0; j < 9; j++) begin
      used |= digit_bit(cell_val(board, cell_idx(r, 4'(j))));
      used |= digit_bit(cell_val(board, cell_idx(4'(j), c)));
      used |= digit_bit(cell_val(board, cell_idx(br + 4'(j / 3), bc + 4'(j % 3))));
    end
    cand = ~used[9:1];

    cnt   = '0;
    digit = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      cnt += 4'(cand[k]);
      if (cand[k] && digit == 4'd0) digit = 4'(k + 1);
    end
  end

endmodule

// File: rtl/sudoku_hint_writer.sv
// Hint / auto-fill engine: scans the board one cell per cycle for a blank empty
// cell with exactly one legal digit and writes it through the game's write port.
//   clk, reset_n : clock, synchronous active-low reset
//   hw (slave)   : request/board inputs, read/row/col/data strobe, busy/done/found/stuck
// Parameters: HOLD_CYC cycles waited after each strobe (>=1); AUTO rescans after each write.
module sudoku_hint_writer
  import sudoku_pkg::*;
#(
  parameter int HOLD_CYC = 2,
  parameter bit AUTO     = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sudoku_hint_writer_if.slave  hw
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  state_t        state, state_n;
  logic [6:0]    idx, idx_n;
  logic [HW-1:0] hold, hold_n;
  logic [3:0]    row_q, row_n;
  logic [3:0]    col_q, col_n;
  logic [3:0]    data_q, data_n;
  logic          found_q, found_n;
  logic          stuck_q, stuck_n;

  logic [3:0]    cur_r, cur_c;
  logic [8:0]    cand;
  logic [3:0]    cnt;
  logic [3:0]    digit;
  logic          eligible;

  assign cur_r    = 4'(idx / 7'd9);
  assign cur_c    = 4'(idx % 7'd9);
  assign eligible = hw.board_blank[idx] && (cell_val(hw.board, idx) == 4'd0);

  sudoku_candidates u_cand (
    .board (hw.board),
    .r     (cur_r),
    .c     (cur_c),
    .cand  (cand),
    .cnt   (cnt),
    .digit (digit)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      hold    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      found_q <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      hold    <= hold_n;
      row_q   <= row_n;
      col_q   <= col_n;
      data_q  <= data_n;
      found_q <= found_n;
      stuck_q <= stuck_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    hold_n  = hold;
    row_n   = row_q;
    col_n   = col_q;
    data_n  = data_q;
    found_n = found_q;
    stuck_n = stuck_q;

    unique case (state)
      IDLE: begin
        if (hw.hint_req && hw.game_active) begin
          state_n = SCAN;
          idx_n   = '0;
          found_n = 1'b0;
          stuck_n = 1'b0;
        end
      end
      SCAN: begin
        // Abort wins over a hit evaluated in the same cycle.
        if (!hw.game_active) begin
          state_n = FIN;
        end else if (eligible && cnt == 4'd1) begin
          row_n   = cur_r;
          col_n   = cur_c;
          data_n  = digit;
          state_n = EMIT;
        end else if (eligible && cand == 9'd0) begin
          stuck_n = 1'b1;
          state_n = FIN;
        end else if (idx == 7'd80) begin
          state_n = FIN;
        end else begin
          idx_n = idx + 7'd1;
        end
      end
      EMIT: begin
        found_n = 1'b1;
        hold_n  = HW'(HOLD_CYC - 1);
        state_n = HOLD;
      end
      HOLD: begin
        if (!hw.game_active) begin
          state_n = FIN;
        end else if (hold == '0) begin
          if (AUTO) begin
            state_n = SCAN;
            idx_n   = '0;
          end else begin
            state_n = FIN;
          end
        end else begin
          hold_n = hold - HW'(1);
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign hw.read  = (state == EMIT);
  assign hw.row   = row_q;
  assign hw.col   = col_q;
  assign hw.data  = data_q;
  assign hw.busy  = (state != IDLE);
  assign hw.done  = (state == FIN);
  assign hw.found = found_q;
  assign hw.stuck = stuck_q;

endmodule

// File: tb/tb_sudoku_hint_writer.sv
// Bench for sudoku_hint_writer: two instances (AUTO=0 and AUTO=1, HOLD_CYC=2)
// share one board; a directed vector table, hand-written reset sequences and
// randomized boards checked against a reference model of the scan rules.
module tb_sudoku_hint_writer;
  import sudoku_pkg::*;

  localparam int HOLD   = 2;
  localparam int BUDGET = 2000;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [BOARD_W-1:0] board;
  logic [CELLS-1:0]   blank;
  logic               game_active;
  logic               req0, req1;

  always #5 clk = ~clk;

  sudoku_hint_writer_if if0 ();
  sudoku_hint_writer_if if1 ();

  assign if0.hint_req    = req0;
  assign if0.game_active = game_active;
  assign if0.board       = board;
  assign if0.board_blank = blank;
  assign if1.hint_req    = req1;
  assign if1.game_active = game_active;
  assign if1.board       = board;
  assign if1.board_blank = blank;

  sudoku_hint_writer #(.HOLD_CYC(HOLD), .AUTO(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .hw(if0));
  sudoku_hint_writer #(.HOLD_CYC(HOLD), .AUTO(1'b1)) dut1 (.clk(clk), .reset_n(reset_n), .hw(if1));

  int n_cmp = 0;
  int n_bad = 0;

  // observed run
  int act_n, act_done, act_done_cnt, act_found, act_stuck;
  int act_cyc[16], act_row[16], act_col[16], act_dat[16];
  // expected run
  int exp_n, exp_done, exp_found, exp_stuck;
  int exp_cyc[16], exp_row[16], exp_col[16], exp_dat[16];

  typedef struct {
    string name;
    int setup, w, abort_at, poke_at, apply;
    int n_rd;
    int c0, r0, l0, d0;
    int c1, r1, l1, d1;
    int done, found, stuck;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int solved(input int r, input int c);
    return ((r * 3 + r / 3 + c + 5) % 9) + 1;
  endfunction

  task automatic put(input int i, input int v);
    board[i*4 +: 4] = 4'(v);
  endtask

  task automatic build(input int setup);
    board = '0;
    blank = '0;
    case (setup)
      0, 1: begin
        for (int i = 0; i < 81; i++) put(i, solved(i / 9, i % 9));
        if (setup == 0) begin
          put(40, 0); blank[40] = 1'b1;
        end else begin
          put(10, 0); blank[10] = 1'b1;
          put(70, 0); blank[70] = 1'b1;
        end
      end
      2, 4: begin
        for (int i = 1; i < 9; i++) put(i, i);
        put(9, (setup == 2) ? 9 : 15);
        blank[0] = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic set_req(input int w, input logic v);
    if (w == 0) req0 = v;
    else req1 = v;
  endtask

  task automatic sample(input int w, output logic rd, output logic [3:0] r, output logic [3:0] c,
                        output logic [3:0] d, output logic dn, output logic fd,
                        output logic st, output logic bz);
    if (w == 0) begin
      rd = if0.read; r = if0.row; c = if0.col; d = if0.data;
      dn = if0.done; fd = if0.found; st = if0.stuck; bz = if0.busy;
    end else begin
      rd = if1.read; r = if1.row; c = if1.col; d = if1.data;
      dn = if1.done; fd = if1.found; st = if1.stuck; bz = if1.busy;
    end
  endtask

  // Cycle n = n-th negedge after the accepting edge (n=1 is SCAN of cell 0).
  task automatic run_req(input int w, input int abort_at, input int poke_at, input int apply);
    logic rd, dn, fd, st, bz;
    logic [3:0] r, c, d;
    int n, extra;
    bit seen;
    act_n = 0; act_done = -1; act_done_cnt = 0; act_found = -1; act_stuck = -1;
    for (int i = 0; i < 16; i++) begin
      act_cyc[i] = -1; act_row[i] = -1; act_col[i] = -1; act_dat[i] = -1;
    end
    @(negedge clk); set_req(w, 1'b1);
    @(negedge clk); set_req(w, 1'b0);
    n = 1; extra = 0; seen = 0;
    while (n <= BUDGET && extra < 3) begin
      sample(w, rd, r, c, d, dn, fd, st, bz);
      if (rd) begin
        if (act_n < 16) begin
          act_cyc[act_n] = n; act_row[act_n] = int'(r);
          act_col[act_n] = int'(c); act_dat[act_n] = int'(d);
        end
        act_n++;
        if (apply != 0 && r < 9 && c < 9) put(int'(r) * 9 + int'(c), int'(d));
      end
      if (dn) begin
        act_done_cnt++;
        if (!seen) begin
          act_done = n; act_found = int'(fd); act_stuck = int'(st);
        end
        seen = 1;
      end
      if (seen) extra++;
      if (n == poke_at) set_req(w, 1'b1);
      else if (n == poke_at + 1) set_req(w, 1'b0);
      if (n == abort_at) game_active = 1'b0;
      n++;
      @(negedge clk);
    end
    if (!seen) check("timeout_no_done", 0, 1);
    set_req(w, 1'b0);
    game_active = 1'b1;
  endtask

  task automatic compare_run(input string name);
    check({name, ".reads"}, act_n, exp_n);
    for (int i = 0; i < exp_n && i < 16; i++) begin
      check($sformatf("%s.rd%0d_cyc", name, i), act_cyc[i], exp_cyc[i]);
      check($sformatf("%s.rd%0d_row", name, i), act_row[i], exp_row[i]);
      check($sformatf("%s.rd%0d_col", name, i), act_col[i], exp_col[i]);
      check($sformatf("%s.rd%0d_data", name, i), act_dat[i], exp_dat[i]);
    end
    check({name, ".done_cyc"}, act_done, exp_done);
    check({name, ".done_pulses"}, act_done_cnt, 1);
    check({name, ".found"}, act_found, exp_found);
    check({name, ".stuck"}, act_stuck, exp_stuck);
  endtask

  // Reference model: legal digits by direct sudoku rules over all peers.
  function automatic int legal_mask(input logic [BOARD_W-1:0] b, input int i);
    int m;
    int r, c, rj, cj, v;
    m = 'h1FF;
    r = i / 9;
    c = i % 9;
    for (int j = 0; j < 81; j++) begin
      rj = j / 9;
      cj = j % 9;
      v  = int'(b[j*4 +: 4]);
      if (j != i && (rj == r || cj == c || (rj / 3 == r / 3 && cj / 3 == c / 3)) && v >= 1 && v <= 9)
        m &= ~(1 << (v - 1));
    end
    return m;
  endfunction

  task automatic model_run(input int w);
    logic [BOARD_W-1:0] b;
    int start, kind, k, dig, m, rd;
    bit fin;
    b = board;
    exp_n = 0; exp_found = 0; exp_stuck = 0; exp_done = -1;
    start = 1;
    fin = 0;
    while (!fin) begin
      kind = 0; k = 0; dig = 0;
      for (int i = 0; i < 81; i++) begin
        if (kind == 0 && blank[i] && b[i*4 +: 4] == 4'd0) begin
          m = legal_mask(b, i);
          if ($countones(m) == 1) begin
            kind = 1; k = i;
            for (int d = 1; d <= 9; d++) if (m == (1 << (d - 1))) dig = d;
          end else if (m == 0) begin
            kind = 2; k = i;
          end
        end
      end
      if (kind == 0) begin
        exp_done = start + 81; fin = 1;
      end else if (kind == 2) begin
        exp_done = start + k + 1; exp_stuck = 1; fin = 1;
      end else begin
        rd = start + k + 1;
        if (exp_n < 16) begin
          exp_cyc[exp_n] = rd; exp_row[exp_n] = k / 9;
          exp_col[exp_n] = k % 9; exp_dat[exp_n] = dig;
        end
        exp_n++;
        exp_found = 1;
        if (w == 0 || exp_n >= 16) begin
          exp_done = rd + HOLD + 1; fin = 1;
        end else begin
          b[k*4 +: 4] = 4'(dig);
          start = rd + HOLD + 1;
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string name, input int w);
    logic rd, dn, fd, st, bz;
    logic [3:0] r, c, d;
    sample(w, rd, r, c, d, dn, fd, st, bz);
    check($sformatf("%s.w%0d.read", name, w), int'(rd), 0);
    check($sformatf("%s.w%0d.row", name, w), int'(r), 0);
    check($sformatf("%s.w%0d.col", name, w), int'(c), 0);
    check($sformatf("%s.w%0d.data", name, w), int'(d), 0);
    check($sformatf("%s.w%0d.busy", name, w), int'(bz), 0);
    check($sformatf("%s.w%0d.done", name, w), int'(dn), 0);
    check($sformatf("%s.w%0d.found", name, w), int'(fd), 0);
    check($sformatf("%s.w%0d.stuck", name, w), int'(st), 0);
  endtask

  initial begin
    logic rd, dn, fd, st, bz;
    logic [3:0] r, c, d;

    vecs[0] = '{"center40",   0, 0,  0,  0, 0, 1, 42, 4, 4, 5,  0, 0, 0, 0,  45, 1, 0};
    vecs[1] = '{"two_auto0",  1, 0,  0,  0, 0, 1, 12, 1, 1, 1,  0, 0, 0, 0,  15, 1, 0};
    vecs[2] = '{"two_auto1",  1, 1,  0,  0, 1, 2, 12, 1, 1, 1, 86, 7, 7, 9, 170, 1, 0};
    vecs[3] = '{"stuck0",     2, 0,  0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,   2, 0, 1};
    vecs[4] = '{"abort20",    3, 0, 21, 10, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  22, 0, 0};
    vecs[5] = '{"nonblank",   3, 0,  0,  0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  82, 0, 0};
    vecs[6] = '{"bad_digit",  4, 0,  0,  0, 0, 1,  2, 0, 0, 9,  0, 0, 0, 0,   5, 1, 0};

    // Reset held with a pending request.
    reset_n = 1'b0; game_active = 1'b1; req0 = 1'b1; req1 = 1'b1;
    build(0);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 0);
    check_idle_outputs("reset", 1);
    req0 = 1'b0; req1 = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      build(vecs[v].setup);
      exp_n = vecs[v].n_rd;
      exp_cyc[0] = vecs[v].c0; exp_row[0] = vecs[v].r0; exp_col[0] = vecs[v].l0; exp_dat[0] = vecs[v].d0;
      exp_cyc[1] = vecs[v].c1; exp_row[1] = vecs[v].r1; exp_col[1] = vecs[v].l1; exp_dat[1] = vecs[v].d1;
      exp_done = vecs[v].done; exp_found = vecs[v].found; exp_stuck = vecs[v].stuck;
      run_req(vecs[v].w, vecs[v].abort_at, vecs[v].poke_at, vecs[v].apply);
      compare_run(vecs[v].name);
    end

    // Reset in the middle of a scan: idle next edge, no done pulse.
    build(3);
    @(negedge clk); req0 = 1'b1;
    @(negedge clk); req0 = 1'b0;
    repeat (29) @(negedge clk);
    sample(0, rd, r, c, d, dn, fd, st, bz);
    check("midscan.busy_before", int'(bz), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("midscan_rst", 0);
    @(negedge clk);
    sample(0, rd, r, c, d, dn, fd, st, bz);
    check("midscan_rst.done_late", int'(dn), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset during HOLD right after a write: registers clear, no done.
    build(0);
    @(negedge clk); req0 = 1'b1;
    @(negedge clk); req0 = 1'b0;
    repeat (41) @(negedge clk);
    sample(0, rd, r, c, d, dn, fd, st, bz);
    check("midhold.read_at_42", int'(rd), 1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("midhold_rst", 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Randomized boards against the reference model.
    for (int it = 0; it < 24; it++) begin
      int w;
      int u;
      w = it % 2;
      build(1);
      blank = '0;
      for (int i = 0; i < 81; i++) begin
        u = int'($urandom_range(0, 99));
        if (u < 8) begin
          put(i, 0);
          blank[i] = ($urandom_range(0, 3) != 0);
        end else if (u < 10) begin
          put(i, int'($urandom_range(10, 15)));
        end else if (u < 12) begin
          put(i, int'($urandom_range(1, 9)));
        end
        if ($urandom_range(0, 9) == 0) blank[i] = 1'b1;
      end
      model_run(w);
      run_req(w, 0, 0, w);
      compare_run($sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
